fetch_stage: RTL and testbench

Instruction-fetch stage with its program counter and IF/ID pipeline register, directly upstream of the hazard unit. It consumes the hazard unit's stall and flush decisions. It also consumes the redirect sources that drive them: NPC operation, interrupt, and eret. Every cycle it issues the fetch address to instruction memory and presents PC, instruction and valid bit to ID.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_stage_npc_sel.sv | 34 +++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage:
// next-PC operation codes, the NOP bubble and default vectors.
package fetch_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_0008;
  localparam logic [31:0] PC_STEP        = 32'h0000_0004;

endpackage

// File: rtl/fetch_stage_npc_sel.sv
// Next-PC priority mux: interrupt, eret, EX redirect,
// then hold on stall or imem wait, else sequential.
module npc_sel
  import fetch_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR = DEF_INT_VECTOR
) (
  input  logic [31:0] pc,
  input  logic        irq,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [2:0]  npc_op,
  input  logic [31:0] target,
  input  logic        stall,
  input  logic        ready,
  output logic [31:0] next_pc,
  output logic        redirect
);

  // Highest-priority source wins; redirects beat stall.
  always_comb begin
    next_pc  = pc + PC_STEP;
    redirect = irq | eret | (npc_op != NPC_PLUS4);
    if (irq)
      next_pc = INT_VECTOR;
    else if (eret)
      next_pc = epc;
    else if (npc_op != NPC_PLUS4)
      next_pc = target;
    else if (stall || !ready)
      next_pc = pc;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register plus IF/ID register.
// Optional perf counters under `FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] INT_VECTOR = DEF_INT_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [2:0]  NPCOp,
  input  logic [31:0] npc_target_in,
  input  logic        INT,
  input  logic        eret,
  input  logic [31:0] epc_in,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_ready,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redirect;

  npc_sel #(
    .INT_VECTOR (INT_VECTOR)
  ) u_npc_sel (
    .pc       (pc),
    .irq      (INT),
    .eret     (eret),
    .epc      (epc_in),
    .npc_op   (NPCOp),
    .target   (npc_target_in),
    .stall    (stall_in),
    .ready    (imem_ready),
    .next_pc  (next_pc),
    .redirect (redirect)
  );

  assign imem_addr = pc;

  // PC register: reset vector or the selected next PC.
  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else
      pc <= next_pc;
  end

  // IF/ID: bubble on kill or imem wait, hold on stall.
  always_ff @(posedge clk) begin
    if (rst || flush_in || redirect) begin
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (stall_in) begin
      if_id_pc    <= if_id_pc;
      if_id_instr <= if_id_instr;
      if_id_valid <= if_id_valid;
    end else if (!imem_ready) begin
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      if_id_pc    <= pc;
      if_id_instr <= imem_instr;
      if_id_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall_ev;
  logic flush_ev;
  logic bubble_ev;

  assign stall_ev  = stall_in & ~redirect;
  assign flush_ev  = flush_in | redirect;
  assign bubble_ev = ~imem_ready & ~stall_in & ~redirect;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (stall_ev && !(&perf_stall_cnt))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_ev && !(&perf_flush_cnt))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (bubble_ev && !(&perf_bubble_cnt))
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed plan steps
// then random traffic against a behavioural fetch model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] IVC = 32'h0000_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        flush_in;
  logic [2:0]  NPCOp;
  logic [31:0] npc_target_in;
  logic        INT;
  logic        eret;
  logic [31:0] epc_in;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_ready;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  logic [31:0] m_iin;
  logic        m_iv;
  logic [31:0] m_sc;
  logic [31:0] m_fc;
  logic [31:0] m_bc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_instr = mem(imem_addr);

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_in      (stall_in),
    .flush_in      (flush_in),
    .NPCOp         (NPCOp),
    .npc_target_in (npc_target_in),
    .INT           (INT),
    .eret          (eret),
    .epc_in        (epc_in),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .imem_ready    (imem_ready),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] c,
                                          input bit ev);
    if (ev && c != 32'hFFFF_FFFF) return c + 1;
    return c;
  endfunction

  // Apply one cycle of inputs, advance the model, compare.
  task automatic step(input bit r, input bit st, input bit fl,
                      input logic [2:0] op, input logic [31:0] tg,
                      input bit it, input bit er,
                      input logic [31:0] ep, input bit rdy);
    bit redir;
    logic [31:0] old_pc;
    @(negedge clk);
    rst = r; stall_in = st; flush_in = fl; NPCOp = op;
    npc_target_in = tg; INT = it; eret = er; epc_in = ep;
    imem_ready = rdy;
    @(posedge clk);
    redir  = it || er || (op != 3'b000);
    old_pc = m_pc;
    if (r) begin
      m_pc = RPC;
      m_ipc = 0; m_iin = NOP; m_iv = 0;
      m_sc = 0; m_fc = 0; m_bc = 0;
    end else begin
      if (it)           m_pc = IVC;
      else if (er)      m_pc = ep;
      else if (op != 0) m_pc = tg;
      else if (st || !rdy) m_pc = old_pc;
      else              m_pc = old_pc + 32'd4;
      if (fl || redir) begin
        m_ipc = 0; m_iin = NOP; m_iv = 0;
      end else if (st) begin
        // hold
      end else if (!rdy) begin
        m_ipc = 0; m_iin = NOP; m_iv = 0;
      end else begin
        m_ipc = old_pc; m_iin = mem(old_pc); m_iv = 1;
      end
      m_sc = sat_inc(m_sc, st && !redir);
      m_fc = sat_inc(m_fc, fl || redir);
      m_bc = sat_inc(m_bc, !rdy && !st && !redir);
    end
    #1;
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_instr", if_id_instr, m_iin);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_iv});
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, m_sc);
    chk("perf_flush", perf_flush_cnt, m_fc);
    chk("perf_bubble", perf_bubble_cnt, m_bc);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
  endtask

  initial begin
    m_pc = RPC; m_ipc = 0; m_iin = NOP; m_iv = 0;
    m_sc = 0; m_fc = 0; m_bc = 0;
    rst = 1; stall_in = 0; flush_in = 0; NPCOp = 0;
    npc_target_in = 0; INT = 0; eret = 0; epc_in = 0;
    imem_ready = 1;

    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_ifid_pc", if_id_pc, 32'h0);
    chk("rst_ifid_instr", if_id_instr, NOP);
    chk("rst_ifid_valid", {31'd0, if_id_valid}, 32'd0);

    // free run: 0,4,8,C
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("run_addr4", imem_addr, 32'h4);
    chk("run_ifid_pc0", if_id_pc, 32'h0);
    chk("run_valid", {31'd0, if_id_valid}, 32'd1);
    run(2);
    chk("run_addrC", imem_addr, 32'hC);
    run(1);
    chk("at_0x10", imem_addr, 32'h10);

    // stall 2 cycles at 0x10
    step(0, 1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1);
    chk("stall_hold", imem_addr, 32'h10);
    chk("stall_ifid", if_id_pc, 32'hC);
    run(1);
    chk("stall_resume", imem_addr, 32'h14);

    // branch with stall: redirect wins
    step(0, 1, 0, 3'b001, 32'h40, 0, 0, 0, 1);
    chk("br_addr", imem_addr, 32'h40);
    chk("br_bubble", {31'd0, if_id_valid}, 32'd0);
    run(1);
    chk("br_tgt_pc", if_id_pc, 32'h40);
    chk("br_tgt_v", {31'd0, if_id_valid}, 32'd1);

    // INT and eret together: INT wins
    step(0, 0, 0, 0, 0, 1, 1, 32'h80, 1);
    chk("int_pc", imem_addr, 32'h8);
    chk("int_flush", if_id_instr, NOP);
    run(1);
    step(0, 0, 0, 0, 0, 0, 1, 32'h80, 1);
    chk("eret_pc", imem_addr, 32'h80);

    // jump to 0x20, then ready low for 3 cycles
    step(0, 0, 0, 3'b010, 32'h20, 0, 0, 0, 1);
    run(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rdy_hold", imem_addr, 32'h24);
    chk("rdy_bubble", {31'd0, if_id_valid}, 32'd0);
    run(1);
    chk("rdy_resume", imem_addr, 32'h28);

    // unilateral flush
    step(0, 0, 1, 0, 0, 0, 0, 0, 1);
    chk("flush_v", {31'd0, if_id_valid}, 32'd0);
    chk("flush_adv", imem_addr, 32'h2C);

    // wrap-around, unaligned passthrough
    step(0, 0, 0, 3'b100, 32'hFFFF_FFFC, 0, 0, 0, 1);
    run(1);
    chk("wrap", imem_addr, 32'h0);
    step(0, 0, 0, 3'b001, 32'h0000_0103, 0, 0, 0, 1);
    run(1);
    chk("unaligned", imem_addr, 32'h107);

    // reset mid-stream with a pending redirect
    step(1, 0, 0, 3'b001, 32'h500, 1, 0, 0, 1);
    chk("rst_mid", imem_addr, RPC);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit r, st, fl, it, er, rdy;
      logic [2:0] op;
      logic [2:0] ops [4];
      ops[0] = 3'b001; ops[1] = 3'b010;
      ops[2] = 3'b100; ops[3] = 3'b000;
      r   = ($urandom_range(0, 49) == 0);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      it  = ($urandom_range(0, 19) == 0);
      er  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 4) != 0);
      op  = ($urandom_range(0, 5) == 0) ?
            ops[$urandom_range(0, 3)] : 3'b000;
      step(r, st, fl, op, $urandom, it, er, $urandom, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
